// File: rtl/ifu_imem_rsp.sv
// Instruction-memory responder for the ifu fetch port: one outstanding request, fixed LATENCY.
// Optional build macro IMEM_MISALIGN_CHK_EN turns a misaligned PC into an access fault.
module ifu_imem_rsp #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [ADDR_WIDTH-1:0] o_rsp_pc,
  output logic [DATA_WIDTH-1:0] o_rsp_inst,
  output logic                  o_rsp_err,
  input  logic                  i_flush,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a valid response holds all its fields stable until it is taken or flushed.

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(4 * DEPTH);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_req_pc;
  logic                  r_rsp_valid;
  logic [ADDR_WIDTH-1:0] r_rsp_pc;
  logic [DATA_WIDTH-1:0] r_rsp_inst;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_load;
  logic                  w_drop;
  logic [ADDR_WIDTH-1:0] w_rd_off;
  logic [ADDR_WIDTH-1:0] w_wr_off;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [IDX_W-1:0]      w_wr_idx;
  logic                  w_rd_err;
  logic                  w_misalign;
  logic                  w_unused;

  // Range test is done one bit wider so BASE_ADDR + 4*DEPTH cannot wrap.
  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] lo;
    lo = {1'b0, BASE_ADDR};
    return ({1'b0, a} >= lo) && ({1'b0, a} < (lo + SPAN));
  endfunction

  assign w_rd_off = r_req_pc - BASE_ADDR;
  assign w_wr_off = i_wr_addr - BASE_ADDR;
  assign w_rd_idx = w_rd_off[IDX_W+1:2];
  assign w_wr_idx = w_wr_off[IDX_W+1:2];
  assign w_unused = ^{w_rd_off[ADDR_WIDTH-1:IDX_W+2], w_rd_off[1:0],
                      w_wr_off[ADDR_WIDTH-1:IDX_W+2], w_wr_off[1:0]};

`ifdef IMEM_MISALIGN_CHK_EN
  assign w_misalign = |r_req_pc[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  assign w_rd_err = ~f_in_range(r_req_pc) | w_misalign;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Flush has priority over both the final WAIT cycle and the response handshake.
  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = 1'b0;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = ~i_flush;
        if (i_req_valid && !i_flush) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_load      = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (i_flush || i_rsp_ready) begin
          w_drop      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= 4'd0;
      r_req_pc    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_pc    <= '0;
      r_rsp_inst  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req_pc <= i_req_pc;
        r_cnt    <= CNT_INIT;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_load) begin
        r_rsp_valid <= 1'b1;
        r_rsp_pc    <= r_req_pc;
        r_rsp_inst  <= w_rd_err ? NOP : r_mem[w_rd_idx];
        r_rsp_err   <= w_rd_err;
      end else if (w_drop) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Array is not reset; a same-edge write is seen by the next read, not this one.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && f_in_range(i_wr_addr)) r_mem[w_wr_idx] <= i_wr_data;
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_pc    = r_rsp_pc;
  assign o_rsp_inst  = r_rsp_inst;
  assign o_rsp_err   = r_rsp_err;

endmodule
